// File: rtl/dice_pkg.sv
// Shared definitions for the dice controller: die codes, display codes, FSM states
// and helpers for the face count and digit patterns.
package dice_pkg;

  localparam int unsigned DIE_W    = 3;
  localparam int unsigned RES_W    = 7;
  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_W    = 12;
  localparam int unsigned LFSR_W   = 16;

  localparam logic [DIE_W-1:0] D4   = 3'd0;
  localparam logic [DIE_W-1:0] D6   = 3'd1;
  localparam logic [DIE_W-1:0] D8   = 3'd2;
  localparam logic [DIE_W-1:0] D10  = 3'd3;
  localparam logic [DIE_W-1:0] D12  = 3'd4;
  localparam logic [DIE_W-1:0] D20  = 3'd5;
  localparam logic [DIE_W-1:0] D30  = 3'd6;
  localparam logic [DIE_W-1:0] D100 = 3'd7;

  localparam logic [DIGIT_W-1:0] CODE_D     = 4'd13;
  localparam logic [DIGIT_W-1:0] CODE_BLANK = 4'd15;

  typedef enum logic [2:0] {SELECT, ROLL, REDUCE, CONVERT, SHOW} state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] d3;
    logic [DIGIT_W-1:0] d2;
    logic [DIGIT_W-1:0] d1;
    logic [DIGIT_W-1:0] d0;
  } digits_t;

  function automatic logic [RES_W-1:0] faces(input logic [DIE_W-1:0] de);
    case (de)
      D4:      faces = 7'd4;
      D6:      faces = 7'd6;
      D8:      faces = 7'd8;
      D10:     faces = 7'd10;
      D12:     faces = 7'd12;
      D20:     faces = 7'd20;
      D30:     faces = 7'd30;
      default: faces = 7'd100;
    endcase
  endfunction

  // 'd' followed by the face count, right-aligned
  function automatic digits_t select_digits(input logic [DIE_W-1:0] de);
    case (de)
      D4:      select_digits = {CODE_BLANK, CODE_BLANK, CODE_D, 4'd4};
      D6:      select_digits = {CODE_BLANK, CODE_BLANK, CODE_D, 4'd6};
      D8:      select_digits = {CODE_BLANK, CODE_BLANK, CODE_D, 4'd8};
      D10:     select_digits = {CODE_BLANK, CODE_D, 4'd1, 4'd0};
      D12:     select_digits = {CODE_BLANK, CODE_D, 4'd1, 4'd2};
      D20:     select_digits = {CODE_BLANK, CODE_D, 4'd2, 4'd0};
      D30:     select_digits = {CODE_BLANK, CODE_D, 4'd3, 4'd0};
      default: select_digits = {CODE_D, 4'd1, 4'd0, 4'd0};
    endcase
  endfunction

  // Drawn value right-aligned with leading zeros blanked
  function automatic digits_t show_digits(input logic [BCD_W-1:0] bcd);
    logic [DIGIT_W-1:0] h;
    logic [DIGIT_W-1:0] t;
    h = bcd[11:8];
    t = bcd[7:4];
    show_digits.d3 = CODE_BLANK;
    show_digits.d2 = (h != 4'd0) ? h : CODE_BLANK;
    show_digits.d1 = (h != 4'd0 || t != 4'd0) ? t : CODE_BLANK;
    show_digits.d0 = bcd[3:0];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 7-bit binary to 3-digit BCD, done pulses 7 cycles
// after start.
module bin2bcd_seq
  import dice_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned CNT_W = 3;

  logic [RES_W-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [BCD_W-1:0] adj_c;

  // Add 3 to every BCD nibble of 5 or more before the next shift
  always_comb begin
    adj_c = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin;
        bcd <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        bcd <= {adj_c[BCD_W-2:0], sh[RES_W-1]};
        sh  <= {sh[RES_W-2:0], 1'b0};
        cnt <= cnt + 3'd1;
        if (cnt == CNT_W'(RES_W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lanceur_de_ctrl.sv
// Dice sequencing controller: die selection, roll animation, LFSR draw reduced
// to 1..faces, BCD conversion and the four display digit codes.
module lanceur_de_ctrl
  import dice_pkg::*;
#(
  parameter int unsigned       ROLL_TICKS = 2_500_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_type,
  input  logic               btn_roll,
  output logic [DIE_W-1:0]   de_value,
  output logic [RES_W-1:0]   result,
  output logic               result_valid,
  output logic               busy,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit3
);

  localparam int unsigned TICK_W = (ROLL_TICKS > 1) ? $clog2(ROLL_TICKS) : 1;
  localparam int unsigned STEP_W = 4;

  state_e              state;
  logic [2:0]          type_sync;
  logic [2:0]          roll_sync;
  logic [LFSR_W-1:0]   lfsr;
  logic [TICK_W-1:0]   anim;
  logic [SAMPLE_W-1:0] sample;
  logic [RES_W-1:0]    rem;
  logic [STEP_W-1:0]   step;
  logic [RES_W-1:0]    result_next;
  logic                bcd_done;
  logic [BCD_W-1:0]    bcd;

  logic                type_rise_c;
  logic                roll_rise_c;
  logic                roll_fall_c;
  logic [RES_W-1:0]    faces_c;
  logic [RES_W:0]      trial_c;
  logic [RES_W-1:0]    rem_step_c;
  logic                bcd_start_c;
  logic [RES_W-1:0]    bcd_bin_c;

  // Two synchroniser flops then one history flop per button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_sync <= '0;
      roll_sync <= '0;
    end else begin
      type_sync <= {type_sync[1:0], btn_type};
      roll_sync <= {roll_sync[1:0], btn_roll};
    end
  end

  assign type_rise_c = type_sync[1] & ~type_sync[2];
  assign roll_rise_c = roll_sync[1] & ~roll_sync[2];
  assign roll_fall_c = ~roll_sync[1] & roll_sync[2];

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[LFSR_W-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // One restoring-division step per REDUCE cycle, sample MSB first
  always_comb begin
    faces_c     = faces(de_value);
    trial_c     = {rem, sample[SAMPLE_W-1]};
    rem_step_c  = (trial_c >= {1'b0, faces_c}) ? RES_W'(trial_c - {1'b0, faces_c})
                                               : trial_c[RES_W-1:0];
    bcd_start_c = (state == REDUCE) && (step == STEP_W'(SAMPLE_W - 1));
    bcd_bin_c   = rem_step_c + 7'd1;
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start_c),
    .bin   (bcd_bin_c),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                          <= SELECT;
      de_value                       <= D6;
      result                         <= '0;
      result_valid                   <= 1'b0;
      busy                           <= 1'b0;
      {digit3, digit2, digit1, digit0} <= select_digits(D6);
      anim                           <= '0;
      sample                         <= '0;
      rem                            <= '0;
      step                           <= '0;
      result_next                    <= '0;
    end else begin
      case (state)
        // Roll press wins over a simultaneous type press
        SELECT, SHOW: begin
          if (roll_rise_c) begin
            state                          <= ROLL;
            busy                           <= 1'b1;
            result_valid                   <= 1'b0;
            result                         <= '0;
            anim                           <= '0;
            {digit3, digit2, digit1, digit0} <= {CODE_BLANK, CODE_BLANK, CODE_BLANK, 4'd0};
          end else if (type_rise_c) begin
            state                          <= SELECT;
            de_value                       <= de_value + 3'd1;
            result                         <= '0;
            result_valid                   <= 1'b0;
            {digit3, digit2, digit1, digit0} <= select_digits(de_value + 3'd1);
          end
        end
        ROLL: begin
          if (anim == TICK_W'(ROLL_TICKS - 1)) begin
            anim   <= '0;
            digit0 <= (digit0 == 4'd9) ? 4'd0 : digit0 + 4'd1;
          end else begin
            anim <= anim + TICK_W'(1);
          end
          if (roll_fall_c) begin
            state  <= REDUCE;
            sample <= lfsr[SAMPLE_W-1:0];
            rem    <= '0;
            step   <= '0;
          end
        end
        REDUCE: begin
          rem    <= rem_step_c;
          sample <= {sample[SAMPLE_W-2:0], 1'b0};
          step   <= step + 4'd1;
          if (bcd_start_c) begin
            result_next <= bcd_bin_c;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          if (bcd_done) begin
            state                          <= SHOW;
            result                         <= result_next;
            result_valid                   <= 1'b1;
            busy                           <= 1'b0;
            {digit3, digit2, digit1, digit0} <= show_digits(bcd);
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule

// File: tb/tb_lanceur_de_ctrl.sv
// Directed bench for lanceur_de_ctrl: selection, display patterns, draw latency,
// forced LFSR samples, button priority, mid-draw reset and model-checked draws.
module tb_lanceur_de_ctrl;

  localparam int unsigned ROLL_TICKS = 4;
  localparam logic [15:0] SEED       = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_type;
  logic       btn_roll;
  logic [2:0] de_value;
  logic [6:0] result;
  logic       result_valid;
  logic       busy;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [15:0] digs;
  logic [15:0] m;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int cur;
  int want;
  int vcount;
  logic [9:0] samp;

  int          faces_tab [8] = '{4, 6, 8, 10, 12, 20, 30, 100};
  logic [15:0] sel_tab   [8] = '{16'hFFD4, 16'hFFD6, 16'hFFD8, 16'hFD10,
                                 16'hFD12, 16'hFD20, 16'hFD30, 16'hD100};

  lanceur_de_ctrl #(.ROLL_TICKS(ROLL_TICKS), .LFSR_SEED(SEED)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_type     (btn_type),
    .btn_roll     (btn_roll),
    .de_value     (de_value),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .digit0       (digit0),
    .digit1       (digit1),
    .digit2       (digit2),
    .digit3       (digit3)
  );

  assign digs = {digit3, digit2, digit1, digit0};

  always #5 clk = ~clk;

  // Reference LFSR, x^16+x^14+x^13+x^11+1
  always @(posedge clk or posedge reset) begin
    if (reset) m <= SEED;
    else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want_v);
    n_assert++;
    assert (obs === want_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want_v);
    end
  endtask

  function automatic logic [15:0] show_exp(input int r);
    int h, t, u;
    logic [3:0] d2, d1, d0;
    h  = r / 100;
    t  = (r / 10) % 10;
    u  = r % 10;
    d2 = (h != 0) ? 4'(h) : 4'hF;
    d1 = (h != 0 || t != 0) ? 4'(t) : 4'hF;
    d0 = 4'(u);
    return {4'hF, d2, d1, d0};
  endfunction

  task automatic press_type();
    @(negedge clk) btn_type = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) btn_type = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic press_roll(input int hold);
    @(negedge clk) btn_roll = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  // Release roll, note the sample the DUT captures, wait (bounded) for valid
  task automatic finish_draw(output int l, output logic [9:0] s);
    @(negedge clk) btn_roll = 1'b0;
    l = 0;
    s = '0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) s = m[9:0];
      if (n > 2 && result_valid === 1'b1) begin
        l = n;
        break;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    btn_type = 1'b0;
    btn_roll = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // T1 reset state
    chk("rst_de", 32'(de_value), 32'd1);
    chk("rst_digits", 32'(digs), 32'hFFD6);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);

    // T2 die selection, wrap 7->0
    for (int i = 1; i <= 7; i++) begin
      press_type();
      cur = (1 + i) % 8;
      chk("type_de", 32'(de_value), 32'(cur));
      chk("type_digits", 32'(digs), 32'(sel_tab[cur]));
    end

    // T3 D6, sample 1023 -> 4, latency and animation
    press_type();
    chk("t3_de", 32'(de_value), 32'd1);
    force dut.lfsr = 16'h03FF;
    press_roll(3);
    chk("roll_busy", 32'(busy), 32'd1);
    chk("roll_valid", 32'(result_valid), 32'd0);
    chk("roll_digits0", 32'(digs), 32'hFFF0);
    repeat (4) @(posedge clk);
    #1;
    chk("roll_digits1", 32'(digs), 32'hFFF1);
    finish_draw(lat, samp);
    chk("t3_latency", 32'(lat), 32'd21);
    chk("t3_result", 32'(result), 32'd4);
    chk("t3_digits", 32'(digs), 32'hFFF4);
    chk("t3_busy", 32'(busy), 32'd0);
    release dut.lfsr;

    // T4 type press from SHOW returns to SELECT, then D100 boundaries
    press_type();
    chk("show_type_de", 32'(de_value), 32'd2);
    chk("show_type_valid", 32'(result_valid), 32'd0);
    chk("show_type_result", 32'(result), 32'd0);
    chk("show_type_digits", 32'(digs), 32'hFFD8);
    repeat (5) press_type();
    chk("t4_de", 32'(de_value), 32'd7);
    force dut.lfsr = 16'h0063;
    press_roll(2);
    finish_draw(lat, samp);
    chk("t4_result100", 32'(result), 32'd100);
    chk("t4_digits100", 32'(digs), 32'hF100);
    force dut.lfsr = 16'h0400;
    press_roll(3);
    chk("reroll_valid", 32'(result_valid), 32'd0);
    chk("reroll_busy", 32'(busy), 32'd1);
    finish_draw(lat, samp);
    chk("t4_latency", 32'(lat), 32'd21);
    chk("t4_result1", 32'(result), 32'd1);
    chk("t4_digits1", 32'(digs), 32'hFFF1);
    release dut.lfsr;

    // T5 simultaneous presses: roll wins; type ignored while rolling
    press_type();
    chk("t5_de", 32'(de_value), 32'd0);
    @(negedge clk);
    btn_type = 1'b1;
    btn_roll = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("both_busy", 32'(busy), 32'd1);
    chk("both_de", 32'(de_value), 32'd0);
    @(negedge clk) btn_type = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) btn_type = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("type_in_roll", 32'(de_value), 32'd0);
    @(negedge clk) btn_type = 1'b0;
    finish_draw(lat, samp);
    chk("t5_latency", 32'(lat), 32'd21);
    chk("t5_range", 32'(result >= 7'd1 && result <= 7'd4), 32'd1);

    // T6 reset during CONVERT
    press_roll(2);
    @(negedge clk) btn_roll = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("conv_busy", 32'(busy), 32'd1);
    chk("conv_valid", 32'(result_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_de", 32'(de_value), 32'd1);
    chk("mid_rst_digits", 32'(digs), 32'hFFD6);
    chk("mid_rst_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    @(negedge clk) reset = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) vcount++;
    end
    chk("no_valid_after_rst", 32'(vcount), 32'd0);

    // Draws on every die checked against the reference LFSR
    for (int d = 0; d < 8; d++) begin
      cur = (1 + d) % 8;
      chk("draw_de", 32'(de_value), 32'(cur));
      for (int k = 0; k < 6; k++) begin
        press_roll((k == 0) ? 1 : int'($urandom_range(1, 6)));
        finish_draw(lat, samp);
        want = (int'(samp) % faces_tab[cur]) + 1;
        chk("draw_latency", 32'(lat), 32'd21);
        chk("draw_result", 32'(result), 32'(want));
        chk("draw_range", 32'(result >= 7'd1 && int'(result) <= faces_tab[cur]), 32'd1);
        chk("draw_digits", 32'(digs), 32'(show_exp(want)));
      end
      press_type();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
